// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, depth and response-tag type for the grid RAM port arbiter.
package ram_port_arbiter_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned ADDRESS_WIDTH = 12;
    localparam int unsigned GRID_DEPTH    = 2500;
    localparam int unsigned NUM_REQ_DEF   = 3;
    localparam int unsigned IDX_W         = 3;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Tag of the access granted last cycle, used to route the RAM read data.
    typedef struct packed {
        logic     is_read;
        logic     err;
        req_idx_t idx;
    } rsp_tag_t;

    function automatic req_idx_t next_ptr(input req_idx_t idx, input int unsigned n);
        int unsigned w_nxt;
        w_nxt = 32'(idx) + 32'd1;
        return (w_nxt >= n) ? '0 : IDX_W'(w_nxt);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus: packed per-requester requests plus the shared read response.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DW      = DATA_WIDTH,
    parameter int unsigned AW      = ADDRESS_WIDTH
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin search: first set request at or after the pointer, wrapping.
module ram_port_arbiter_rr_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output req_idx_t           o_idx_c,
    output logic               o_any_c
);

    // Outer loop is search distance from the pointer, so the first hit wins.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned c = 0; c < NUM_REQ; c++) begin
                if (!o_any_c && i_req[c] && (((32'(i_ptr) + k) % NUM_REQ) == c)) begin
                    o_grant_c[c] = 1'b1;
                    o_idx_c      = IDX_W'(c);
                    o_any_c      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency grid RAM between NUM_REQ requesters.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DEPTH   = GRID_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ram_port_arbiter_if.slave        bus,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic                     ram_write_en,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic                     busy
);

    logic [NUM_REQ-1:0]       w_grant_raw;
    logic [NUM_REQ-1:0]       w_grant;
    req_idx_t                 w_idx;
    logic                     w_any_raw;
    logic                     w_any;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic                     w_we;
    logic                     w_in_range;
    logic [NUM_REQ-1:0]       w_rsp_valid;

    req_idx_t                 r_rr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_last_addr;
    rsp_tag_t                 r_tag;

    ram_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req     (bus.req_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_grant_raw),
        .o_idx_c   (w_idx),
        .o_any_c   (w_any_raw)
    );

    // No grant may leak out while reset is asserted.
    assign w_grant = rst_n ? w_grant_raw : '0;
    assign w_any   = rst_n & w_any_raw;

    // One-hot grant selects the active requester's slice.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_addr  = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_we    = bus.req_we[i];
            end
        end
    end

    assign w_in_range = (32'(w_addr) < DEPTH);

    assign bus.req_ready = w_grant;
    assign ram_addr      = w_any ? w_addr : r_last_addr;
    assign ram_data_in   = w_wdata;
    assign ram_write_en  = w_any & w_we & w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_last_addr <= '0;
            r_tag       <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr    <= next_ptr(w_idx, NUM_REQ);
                r_last_addr <= w_addr;
            end
            r_tag.is_read <= w_any & ~w_we;
            r_tag.err     <= w_any & ~w_we & ~w_in_range;
            r_tag.idx     <= w_idx;
        end
    end

    // Response routing: RAM data lands one cycle after the read grant.
    always_comb begin
        w_rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = r_tag.is_read && (r_tag.idx == IDX_W'(i));
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = (r_tag.is_read && !r_tag.err) ? ram_data_out : '0;
    assign bus.rsp_err   = r_tag.is_read & r_tag.err;
    assign busy          = (|bus.req_valid) | (|w_rsp_valid);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-output RAM.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic                     ram_write_en;
    logic [DATA_WIDTH-1:0]    ram_data_out;
    logic                     busy;

    int n_pass  = 0;
    int n_total = 0;

    ram_port_arbiter_if #(.NUM_REQ(3), .DW(DATA_WIDTH), .AW(ADDRESS_WIDTH)) bus ();

    ram_port_arbiter #(.NUM_REQ(3), .DEPTH(2500)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out),
        .busy         (busy)
    );

    logic [DATA_WIDTH-1:0] mem [0:4095];
    bit                    loaded;

    // RAM words beyond the grid carry markers that must never reach a requester.
    always @(posedge clk) begin
        if (!loaded) begin
            mem[2500] <= 16'h5A5A;
            mem[4095] <= 16'h0FFF;
            loaded    <= 1'b1;
        end
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic we, input logic [11:0] a, input logic [15:0] d);
        bus.req_valid = bus.req_valid | (3'b001 << r);
        bus.req_we    = (bus.req_we & ~(3'b001 << r)) | (3'(we) << r);
        bus.req_addr  = (bus.req_addr & ~(36'hFFF << (12*r))) | (36'(a) << (12*r));
        bus.req_wdata = (bus.req_wdata & ~(48'hFFFF << (16*r))) | (48'(d) << (16*r));
    endtask

    task automatic clr_req();
        bus.req_valid = '0;
    endtask

    logic [15:0] exp_d [3];

    initial begin
        exp_d[0] = 16'hABCD;
        exp_d[1] = 16'h2020;
        exp_d[2] = 16'h3030;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset and idle
        next_cyc();
        settle();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_we", 32'(ram_write_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        set_req(0, 1'b1, 12'd10, 16'h1111);
        #1;
        chk("rst_ready_gated", 32'(bus.req_ready), 32'h0);
        chk("rst_we_gated", 32'(ram_write_en), 32'h0);
        clr_req();
        next_cyc();
        rst_n = 1'b1;

        // Write then read the same address
        set_req(0, 1'b1, 12'd10, 16'hABCD);
        settle();
        chk("wr_ready", 32'(bus.req_ready), 32'h1);
        chk("wr_we", 32'(ram_write_en), 32'h1);
        chk("wr_addr", 32'(ram_addr), 32'd10);
        chk("wr_din", 32'(ram_data_in), 32'hABCD);
        next_cyc();
        clr_req();
        set_req(1, 1'b0, 12'd10, 16'h0);
        settle();
        chk("rd_ready", 32'(bus.req_ready), 32'h2);
        chk("rd_we", 32'(ram_write_en), 32'h0);
        next_cyc();
        clr_req();
        settle();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("rd_rsp_data", 32'(bus.rsp_data), 32'hABCD);
        chk("rd_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        chk("hold_addr", 32'(ram_addr), 32'd10);
        next_cyc();
        settle();
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        next_cyc();

        // Preload: pointer is 2, lone req1 wraps to 1; req2 then moves pointer to 0
        set_req(1, 1'b1, 12'd20, 16'h2020);
        settle();
        chk("pre1_ready", 32'(bus.req_ready), 32'h2);
        next_cyc();
        clr_req();
        set_req(2, 1'b1, 12'd30, 16'h3030);
        settle();
        chk("pre2_ready", 32'(bus.req_ready), 32'h4);
        next_cyc();
        clr_req();

        // Three continuous readers rotate 0,1,2
        set_req(0, 1'b0, 12'd10, 16'h0);
        set_req(1, 1'b0, 12'd20, 16'h0);
        set_req(2, 1'b0, 12'd30, 16'h0);
        for (int k = 0; k < 9; k++) begin
            settle();
            chk($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'h1 << (k % 3));
            if (k > 0) begin
                chk($sformatf("rr_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'h1 << ((k - 1) % 3));
                chk($sformatf("rr_rsp_data_%0d", k), 32'(bus.rsp_data), 32'(exp_d[(k - 1) % 3]));
            end
            next_cyc();
        end
        clr_req();
        settle();
        chk("rr_last_valid", 32'(bus.rsp_valid), 32'h4);
        chk("rr_last_data", 32'(bus.rsp_data), 32'h3030);
        next_cyc();

        // Out-of-range read and write
        set_req(0, 1'b1, 12'd2499, 16'h2499);
        settle();
        chk("edge_wr_we", 32'(ram_write_en), 32'h1);
        next_cyc();
        clr_req();
        set_req(2, 1'b0, 12'd2500, 16'h0);
        settle();
        chk("oor_rd_ready", 32'(bus.req_ready), 32'h4);
        next_cyc();
        clr_req();
        set_req(2, 1'b1, 12'd4095, 16'hDEAD);
        settle();
        chk("oor_wr_ready", 32'(bus.req_ready), 32'h4);
        chk("oor_wr_we", 32'(ram_write_en), 32'h0);
        chk("oor_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("oor_rsp_err", 32'(bus.rsp_err), 32'h1);
        chk("oor_rsp_data", 32'(bus.rsp_data), 32'h0);
        next_cyc();
        clr_req();
        set_req(0, 1'b0, 12'd2499, 16'h0);
        settle();
        chk("after_wr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        next_cyc();
        clr_req();
        settle();
        chk("edge_rd_valid", 32'(bus.rsp_valid), 32'h1);
        chk("edge_rd_data", 32'(bus.rsp_data), 32'h2499);
        chk("edge_rd_err", 32'(bus.rsp_err), 32'h0);
        chk("oor_mem_untouched", 32'(mem[4095]), 32'h0FFF);
        next_cyc();

        // Lone requester at pointer 2, then a late joiner
        set_req(1, 1'b1, 12'd40, 16'h0101);
        settle();
        chk("lone_wr_ready", 32'(bus.req_ready), 32'h2);
        next_cyc();
        clr_req();
        set_req(1, 1'b0, 12'd40, 16'h0);
        settle();
        chk("lone_rd_ready", 32'(bus.req_ready), 32'h2);
        next_cyc();
        set_req(0, 1'b0, 12'd10, 16'h0);
        settle();
        chk("join_ready", 32'(bus.req_ready), 32'h1);
        chk("join_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("join_rsp_data", 32'(bus.rsp_data), 32'h0101);
        next_cyc();
        clr_req();
        set_req(1, 1'b0, 12'd40, 16'h0);
        settle();
        chk("after_join_ready", 32'(bus.req_ready), 32'h2);
        chk("after_join_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("after_join_rsp_data", 32'(bus.rsp_data), 32'hABCD);
        next_cyc();
        clr_req();
        settle();
        chk("tail_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("tail_rsp_data", 32'(bus.rsp_data), 32'h0101);
        next_cyc();

        // Reset while a read is in flight
        set_req(2, 1'b0, 12'd30, 16'h0);
        settle();
        chk("pre_rst_ready", 32'(bus.req_ready), 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h1);
        next_cyc();
        chk("post_edge_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("post_edge_rsp_err", 32'(bus.rsp_err), 32'h0);
        clr_req();
        rst_n = 1'b1;
        set_req(0, 1'b0, 12'd10, 16'h0);
        set_req(1, 1'b0, 12'd20, 16'h0);
        set_req(2, 1'b0, 12'd30, 16'h0);
        settle();
        chk("restart_ready", 32'(bus.req_ready), 32'h1);
        next_cyc();
        clr_req();
        settle();
        chk("restart_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("restart_rsp_data", 32'(bus.rsp_data), 32'hABCD);
        next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
